banco_reg_param: RTL

- Parametrised successor to the single-cycle datapath register bank.
- Two asynchronous read ports and one synchronous write port.
- Same-cycle write-to-read bypass on both read ports.
- Hardware clear sequencer initialises every entry after reset or on request, so the datapath needs no initial-block preload.
- Sits between instruction decode and the ALU/write-back mux.

---
 rtl/banco_reg_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/banco_reg_param.sv
// rtl/banco_reg_param.sv - parametrised 2R/1W register bank with clear sweep and write bypass
// Optional: define BANCOREG_ZERO_REG_EN to hardwire entry 0 to zero.
module banco_reg_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] AW,
  input  logic [DATA_W-1:0] Di,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // ptr is one bit wider than the address so DEPTH == 2**ADDR_W needs no wrap
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W:0]   ptr;
  logic              ready;
  logic              aw_ok;
  logic              aw_live;
  logic              wr_en;
  logic              drop;

  assign ready = (state == S_READY);
  assign busy  = ~ready;
  assign aw_ok = ({1'b0, AW} < DEPTH_P);

`ifdef BANCOREG_ZERO_REG_EN
  assign aw_live = (AW != '0);
`else
  assign aw_live = 1'b1;
`endif

  assign wr_en = RegWrite & ready & ~clr & aw_ok & aw_live;
  // A write to the hardwired zero entry is discarded silently, not flagged
  assign drop  = RegWrite & (~ready | clr | ~aw_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= drop;
      if (clr) begin
        state <= S_CLEAR;
        ptr   <= '0;
      end else if (!ready) begin
        ptr <= ptr + ONE_P;
        if (ptr == LAST_P) begin
          state <= S_READY;
        end
      end
    end
  end

  // Array has no reset; gating on rst abandons any write or sweep step in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready && !clr) begin
        mem[ptr[ADDR_W-1:0]] <= '0;
      end else if (wr_en) begin
        mem[AW] <= Di;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    if (ready && ({1'b0, ra} < DEPTH_P)) begin
      if (wr_en && (AW == ra)) begin
        v = Di;
      end else begin
        v = mem[ra];
      end
    end
`ifdef BANCOREG_ZERO_REG_EN
    if (ra == '0) begin
      v = '0;
    end
`endif
    return v;
  endfunction

  assign DR1 = rd_port(RA1);
  assign DR2 = rd_port(RA2);

endmodule
